// File: rtl/dice_roller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dice_roller : two-die roller, LFSR-driven animation with craps-style turn phase
// Revision    : 1.0
// ============================================================================
module dice_roller #(
  parameter int          ROLL_CYCLES = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll,
  input  logic       game_over,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [1:0] turn,
  output logic       busy,
  output logic       roll_done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ROLL = 1'b1
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(ROLL_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [15:0] lfsr;
  logic        sync1, sync2, sync3;
  logic        roll_req;
  logic [3:0]  num1_next, num2_next;
  logic [1:0]  turn_next;
  logic        done_next;
  logic [2:0]  cand1, cand2;
  logic        cand1_ok, cand2_ok;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr  <= SEED;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sync1 <= roll;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign roll_req = sync2 & ~sync3;
  assign cand1    = lfsr[2:0];
  assign cand2    = lfsr[5:3];
  assign cand1_ok = (cand1 != 3'd0) && (cand1 != 3'd7);
  assign cand2_ok = (cand2 != 3'd0) && (cand2 != 3'd7);
  assign busy     = (state == ROLL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      num1      <= 4'd1;
      num2      <= 4'd1;
      turn      <= 2'b00;
      roll_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      num1      <= num1_next;
      num2      <= num2_next;
      turn      <= turn_next;
      roll_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    num1_next  = num1;
    num2_next  = num2;
    turn_next  = turn;
    done_next  = 1'b0;
    if (game_over) begin
      // Game end overrides everything, including a coincident request or final roll
      state_next = IDLE;
      turn_next  = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (roll_req) begin
            state_next = ROLL;
            cnt_next   = CNT_INIT;
          end
        end
        ROLL: begin
          if (cand1_ok) num1_next = {1'b0, cand1};
          if (cand2_ok) num2_next = {1'b0, cand2};
          if (cnt == 8'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
            turn_next  = (turn == 2'b00) ? 2'b01 : 2'b10;
          end else begin
            cnt_next = cnt - 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dice_roller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dice_roller : directed bench with a per-cycle reference model of the roller
// Revision       : 1.0
// ============================================================================
module tb_dice_roller;

  localparam int          RC   = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0, rst = 1'b0, roll = 1'b0, game_over = 1'b0;
  logic [3:0] num1, num2;
  logic [1:0] turn;
  logic       busy, roll_done;

  dice_roller #(.ROLL_CYCLES(RC), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .roll(roll), .game_over(game_over),
    .num1(num1), .num2(num2), .turn(turn), .busy(busy), .roll_done(roll_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: dice phase, die values, turn phase, and the roll history
  logic [15:0] m_lfsr = SEED;
  int m_n1 = 1, m_n2 = 1, m_turn = 0, m_left = 0;
  bit m_busy = 0, m_done = 0, m_req = 0;
  bit h0 = 0, h1 = 0, h2 = 0;
  int c1, c2;

  // Feedback = parity of the state bits for exponents 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr = SEED; m_n1 = 1; m_n2 = 1; m_turn = 0; m_left = 0;
      m_busy = 0; m_done = 0; h0 = 0; h1 = 0; h2 = 0;
    end else begin
      m_req  = h1 && !h2;
      m_done = 0;
      if (game_over) begin
        m_turn = 0;
        m_busy = 0;
      end else if (m_busy) begin
        c1 = int'(m_lfsr[2:0]);
        c2 = int'(m_lfsr[5:3]);
        if (c1 >= 1 && c1 <= 6) m_n1 = c1;
        if (c2 >= 1 && c2 <= 6) m_n2 = c2;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_turn = (m_turn == 0) ? 1 : 2;
        end else begin
          m_left--;
        end
      end else if (m_req) begin
        m_busy = 1;
        m_left = RC - 1;
      end
      m_lfsr = lfsr_next(m_lfsr);
      h2 = h1; h1 = h0; h0 = roll;
    end
  end

  always @(negedge clk) begin
    check("num1", num1, m_n1);
    check("num2", num2, m_n2);
    check("turn", turn, m_turn);
    check("busy", busy, m_busy);
    check("roll_done", roll_done, m_done);
    check("num1_range", (num1 >= 4'd1 && num1 <= 4'd6), 1);
    check("num2_range", (num2 >= 4'd1 && num2 <= 4'd6), 1);
    check("busy_done_excl", busy & roll_done, 0);
    if (roll_done) done_cnt++;
  end

  task automatic start_roll(output int lat);
    @(negedge clk) roll = 1'b1;
    lat = 0;
    while (!busy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(output int dur);
    dur = 0;
    while (busy && dur < 40) begin
      @(negedge clk);
      dur++;
    end
  endtask

  task automatic full_press(input string tag, input int exp_turn);
    int lat, dur;
    start_roll(lat);
    check({tag, "_latency"}, lat, 3);
    wait_idle(dur);
    check({tag, "_busy_len"}, dur, RC);
    check({tag, "_done_pulse"}, roll_done, 1);
    check({tag, "_turn"}, turn, exp_turn);
    @(negedge clk) roll = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int lat, dur, snap;
    // Reset held with roll toggling
    repeat (5) @(negedge clk) roll = ~roll;
    @(negedge clk) roll = 1'b0;
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    #1 check("reset_no_done", done_cnt, 0);

    // Three presses: turn 01, 10, 10
    full_press("press1", 1);
    full_press("press2", 2);
    full_press("press3", 2);
    #1 check("three_dones", done_cnt, 3);

    // game_over pulse after point roll
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    check("go_turn_clear", turn, 0);
    check("go_busy", busy, 0);
    repeat (3) @(negedge clk);

    // Second edge issued mid-roll is ignored
    snap = done_cnt;
    start_roll(lat);
    check("ign_latency", lat, 3);
    repeat (4) @(negedge clk);
    roll = 1'b0;
    repeat (2) @(negedge clk);
    roll = 1'b1;
    repeat (3) @(negedge clk);
    roll = 1'b0;
    wait_idle(dur);
    check("ign_busy_len", dur, RC - 9);
    repeat (10) @(negedge clk);
    #1 check("ign_single_done", done_cnt, snap + 1);
    check("ign_turn", turn, 1);
    check("ign_no_reroll", busy, 0);

    // game_over during a roll
    snap = done_cnt;
    start_roll(lat);
    repeat (5) @(negedge clk);
    game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    check("go_roll_busy", busy, 0);
    check("go_roll_turn", turn, 0);
    roll = 1'b0;
    repeat (25) @(negedge clk);
    #1 check("go_roll_no_done", done_cnt, snap);

    // Asynchronous reset mid-roll
    snap = done_cnt;
    start_roll(lat);
    repeat (4) @(negedge clk);
    roll = 1'b0;
    #2 rst = 1'b0;
    #1 check("arst_num1", num1, 1);
    check("arst_num2", num2, 1);
    check("arst_turn", turn, 0);
    check("arst_busy", busy, 0);
    check("arst_done", roll_done, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (25) @(negedge clk);
    #1 check("arst_no_done", done_cnt, snap);
    check("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter: ROLL_CYCLES, default 16, number of clock cycles the dice animate per roll (legal range 2..255).
REQ-002 Parameter: SEED, default 16'hACE1, LFSR reset value (must be nonzero).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: roll  input  1  raw roll button level, asynchronous to clk.
REQ-006 Port: game_over  input  1  level from downstream turn logic (win OR lose); clears the turn sequence.
REQ-007 Port: num1  output  4  die 1 value, 1..6, zero-extended.
REQ-008 Port: num2  output  4  die 2 value, 1..6, zero-extended.
REQ-009 Port: turn  output  2  roll phase: 00 = no roll yet, 01 = first roll done, 10 = subsequent (point) roll done.
REQ-010 Port: busy  output  1  high while dice are animating.
REQ-011 Port: roll_done  output  1  one-cycle pulse when num1/num2/turn hold a final roll result.

Function
REQ-012 roll SHALL pass through a 2-flop synchronizer; a roll request is a 0->1 transition of the second synchronizer flop, registered by a third flop (request visible 3 cycles after roll rises).
REQ-013 A 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL shift every cycle in every state, independent of roll.
REQ-014 Candidate die values: c1 = lfsr[2:0], c2 = lfsr[5:3]; a candidate of 0 or 7 is rejected and that die holds its previous value for the cycle.
REQ-015 FSM states: IDLE, ROLL.
REQ-016 IDLE: num1/num2/turn held; busy=0; a roll request moves to ROLL and loads an 8-bit down-counter with ROLL_CYCLES-1.
REQ-017 ROLL: busy=1; every cycle num1/num2 update per REQ-014; counter decrements; further roll requests ignored.
REQ-018 ROLL with counter==0: final num1/num2 update per REQ-014, roll_done=1 for that one cycle (asserted registered, coincident with final values), turn advances, next state IDLE.
REQ-019 Turn advance: 00->01, 01->10, 10->10 (saturates).
REQ-020 Roll latency: roll_done asserts exactly ROLL_CYCLES cycles after the cycle busy first goes high; busy and roll_done never both high.
REQ-021 game_over high in any state SHALL, on the next edge, force turn=00, state=IDLE, busy=0, suppress any roll_done that cycle; num1/num2 hold last values.
REQ-022 game_over and a roll request in the same cycle: game_over wins, request discarded.
REQ-023 Holding roll high SHALL start only one roll; a new roll requires release and re-press.
REQ-024 num1 and num2 SHALL never take values outside 1..6 at any time after reset.

Reset
REQ-025 With rst low: state=IDLE, lfsr=SEED, num1=4'd1, num2=4'd1, turn=2'b00, busy=0, roll_done=0, synchronizer and edge flops=0, counter=0.
REQ-026 Reset deassertion mid-ROLL SHALL resume from the full reset state; no roll_done is produced for the aborted roll.

Verification
REQ-027 Reset: rst low 5 cycles, roll toggling -> num1=1, num2=1, turn=00, busy=0, roll_done=0 throughout.
REQ-028 Single roll, ROLL_CYCLES=16: roll 0->1 held 20 cycles -> busy high 16 cycles starting 3 cycles after edge, one roll_done pulse, turn=01, num1/num2 match golden LFSR model from SEED.
REQ-029 Turn sequencing: three separate presses -> turn 01, 10, 10; exactly three roll_done pulses; every num1/num2 sample in 1..6.
REQ-030 Ignored press: second roll edge issued mid-ROLL -> no extra roll; single roll_done; turn increments by one.
REQ-031 game_over: after turn=10, pulse game_over 1 cycle -> turn=00 next cycle, num1/num2 unchanged; game_over asserted during ROLL -> busy drops next cycle, no roll_done, turn=00.
REQ-032 Async reset mid-roll: rst low for 1 cycle while busy=1 -> all outputs return to REQ-025 values immediately, no roll_done after release.
